// File: rtl/eth_rr_arb.sv
// Packet-granular round-robin arbiter merging NPORTS ingress FIFOs onto one registered egress stream.
// Optional feature macro: ETH_RR_ARB_ORPHAN_DROP_EN (discard heads lacking start while idle).

package eth_rr_arb_pkg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WORD_W = DATA_W + 2;

  typedef struct packed {
    logic              eop;
    logic              sop;
    logic [DATA_W-1:0] data;
  } word_t;
endpackage

module eth_rr_arb
  import eth_rr_arb_pkg::*;
#(
  parameter  int unsigned NPORTS = 4,
  localparam int unsigned PW     = $clog2(NPORTS)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NPORTS-1:0]        fifo_empty,
  input  logic [WORD_W*NPORTS-1:0] fifo_rd_data,
  output logic [NPORTS-1:0]        fifo_rd_en,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_start,
  output logic                     o_end,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [PW-1:0]            o_port,
  output logic                     o_drop
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   grant_q, grant_d;
  logic [PW-1:0]   last_q, last_d;
  word_t           out_q, out_d;
  logic            valid_q, valid_d;
  logic [PW-1:0]   port_q, port_d;
  logic            drop_q, drop_d;

  word_t           head [NPORTS];
  word_t           head_sel;
  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] drop_vec;
  logic            found;
  logic [PW-1:0]   pick;
  logic            pop;

  // Unpack per-port head words.
  always_comb begin
    for (int unsigned p = 0; p < NPORTS; p++) begin
      head[p] = fifo_rd_data[WORD_W*p +: WORD_W];
    end
  end

  assign head_sel = head[grant_q];

`ifdef ETH_RR_ARB_ORPHAN_DROP_EN
  // Heads without a start bit are flushed while idle and may not compete.
  always_comb begin
    drop_vec = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      drop_vec[PW'(p)] = !fifo_empty[PW'(p)] && !head[p].sop;
    end
  end
`else
  assign drop_vec = '0;
`endif

  assign req = ~fifo_empty & ~drop_vec;

  // Rotating priority search starting just after the last served port.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 1; i <= NPORTS; i++) begin
      logic [PW-1:0] idx;
      idx = PW'((32'(last_q) + i) % NPORTS);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign pop = (state_q == XFER) && !fifo_empty[grant_q] && (!valid_q || o_ready);

  // Next-state, pop strobes and output-register load.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    out_d      = out_q;
    valid_d    = valid_q;
    port_d     = port_q;
    drop_d     = 1'b0;
    fifo_rd_en = '0;

    case (state_q)
      IDLE: begin
        if (valid_q && o_ready) begin
          valid_d = 1'b0;
        end
        fifo_rd_en = drop_vec;
        drop_d     = |drop_vec;
        if (found) begin
          grant_d = pick;
          state_d = XFER;
        end
      end
      XFER: begin
        if (pop) begin
          fifo_rd_en[grant_q] = 1'b1;
          out_d               = head_sel;
          port_d              = grant_q;
          valid_d             = 1'b1;
          if (head_sel.eop) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end else if (valid_q && o_ready) begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= PW'(NPORTS - 1);
      out_q   <= '0;
      valid_q <= 1'b0;
      port_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      port_q  <= port_d;
      drop_q  <= drop_d;
    end
  end

  assign o_data  = out_q.data;
  assign o_start = out_q.sop;
  assign o_end   = out_q.eop;
  assign o_valid = valid_q;
  assign o_port  = port_q;
  assign o_drop  = drop_q;

endmodule

// File: tb/tb_eth_rr_arb.sv
// Bench for eth_rr_arb: bench-owned FIFO queues, packet-level round-robin reference model, random traffic.

module tb_eth_rr_arb;

  localparam int unsigned NP     = 4;
  localparam int unsigned PWB    = 2;
  localparam int unsigned WW     = 34;
  localparam int          BUDGET = 3000;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NP-1:0]      fifo_empty;
  logic [WW*NP-1:0]   fifo_rd_data;
  logic [NP-1:0]      fifo_rd_en;
  logic [31:0]        o_data;
  logic               o_start;
  logic               o_end;
  logic               o_valid;
  logic               o_ready;
  logic [PWB-1:0]     o_port;
  logic               o_drop;

  logic [WW-1:0]      head_w [NP];
  logic [WW-1:0]      fq [NP][$];
  logic [WW-1:0]      mq [NP][$];
  logic [PWB+WW-1:0]  exp_q [$];
  int                 stall_left [NP];
  int                 model_last;
  int                 n_checks = 0;
  int                 n_errors = 0;

  eth_rr_arb #(.NPORTS(NP)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .o_data       (o_data),
    .o_start      (o_start),
    .o_end        (o_end),
    .o_valid      (o_valid),
    .o_ready      (o_ready),
    .o_port       (o_port),
    .o_drop       (o_drop)
  );

  for (genvar g = 0; g < NP; g++) begin : g_rd
    assign fifo_rd_data[WW*g +: WW] = head_w[g];
  end

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      fifo_empty[PWB'(p)] = (fq[p].size() == 0) || (stall_left[p] > 0);
      head_w[p]           = (fq[p].size() > 0) ? fq[p][0] : '0;
    end
  endtask

  task automatic push_word(input int p, input logic [WW-1:0] w);
    fq[p].push_back(w);
    mq[p].push_back(w);
  endtask

  task automatic load_pkt(input int p, input int len);
    for (int i = 0; i < len; i++) begin
      push_word(p, {(i == len - 1), (i == 0), 32'($urandom)});
    end
  endtask

  // Packet-level round robin: next non-empty port after the last served one sends a whole packet.
  task automatic model_pkts();
    logic [WW-1:0] w;
    int            p;
    bit            found;
    forever begin
      found = 0;
      p     = 0;
      for (int i = 1; i <= NP; i++) begin
        if (!found && mq[(model_last + i) % NP].size() > 0) begin
          found = 1;
          p     = (model_last + i) % NP;
        end
      end
      if (!found) break;
      do begin
        w = mq[p].pop_front();
        exp_q.push_back({PWB'(p), w});
      end while (!w[WW-1] && mq[p].size() > 0);
      model_last = p;
    end
  endtask

  function automatic logic ready_val(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 9) < 7);
      default: return !(cyc >= 3 && cyc <= 7);
    endcase
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    for (int p = 0; p < NP; p++) begin
      fq[p].delete();
      mq[p].delete();
      stall_left[p] = 0;
    end
    exp_q.delete();
    model_last = NP - 1;
    o_ready    = 1'b1;
    drive_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    check_eq("reset_valid", o_valid, 0);
    check_eq("reset_out", {o_port, o_end, o_start, o_data}, 0);
    check_eq("reset_drop", o_drop, 0);
    check_eq("reset_rd_en", fifo_rd_en, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_batch(input string name, input int mode, input int smin, input int smax,
                           input bit timing);
    int                cyc      = 0;
    bit                held     = 0;
    bit                first    = 1;
    int                last_cyc = 0;
    bit                last_end = 0;
    int                left     = 0;
    logic [WW-1:0]     w;
    logic [PWB+WW:0]   held_v   = '0;
    logic [PWB+WW-1:0] e;
    model_pkts();
    o_ready = ready_val(mode, 0);
    drive_inputs();
    while (exp_q.size() > 0 && cyc < BUDGET) begin
      @(negedge clk);
      check_eq({name, ":rd_en_empty"}, fifo_rd_en & fifo_empty, 0);
      check_eq({name, ":rd_en_onehot"}, $onehot0(fifo_rd_en), 1);
      if (o_valid && !o_ready) check_eq({name, ":rd_en_stall"}, fifo_rd_en, 0);
      if (held) check_eq({name, ":hold"}, {o_valid, o_port, o_end, o_start, o_data}, held_v);
      held   = o_valid && !o_ready;
      held_v = {o_valid, o_port, o_end, o_start, o_data};
      check_eq({name, ":drop"}, o_drop, 0);
      if (o_valid && o_ready) begin
        e = exp_q.pop_front();
        check_eq({name, ":word"}, {o_port, o_end, o_start, o_data}, e);
        if (timing) begin
          if (first) check_eq({name, ":latency"}, cyc, 2);
          else       check_eq({name, ":gap"}, cyc - last_cyc, last_end ? 2 : 1);
        end
        first    = 0;
        last_cyc = cyc;
        last_end = o_end;
      end
      for (int p = 0; p < NP; p++) begin
        if (fifo_rd_en[PWB'(p)] && fq[p].size() > 0) begin
          w = fq[p].pop_front();
          if (!w[WW-1] && smax > 0) stall_left[p] = $urandom_range(smax, smin) + 1;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int p = 0; p < NP; p++) if (stall_left[p] > 0) stall_left[p]--;
      o_ready = ready_val(mode, cyc);
      drive_inputs();
    end
    check_eq({name, ":timeout"}, exp_q.size(), 0);
    o_ready = 1'b1;
    for (int p = 0; p < NP; p++) stall_left[p] = 0;
    drive_inputs();
    repeat (3) begin
      @(negedge clk);
      check_eq({name, ":drain_valid"}, o_valid, 0);
      check_eq({name, ":drain_rd_en"}, fifo_rd_en, 0);
      @(posedge clk);
      #1;
    end
    for (int p = 0; p < NP; p++) left += fq[p].size();
    check_eq({name, ":leftover"}, left, 0);
  endtask

  initial begin
    fifo_empty = '1;
    o_ready    = 1'b1;
    for (int p = 0; p < NP; p++) head_w[p] = '0;
    do_reset();

    push_word(0, {1'b0, 1'b1, 32'hA000_0001});
    push_word(0, {1'b0, 1'b0, 32'hA000_0002});
    push_word(0, {1'b1, 1'b0, 32'hA000_0003});
    run_batch("single_pkt", 0, 0, 0, 1);

    do_reset();
    for (int k = 0; k < 2; k++) for (int p = 0; p < NP; p++) load_pkt(p, 2);
    run_batch("round_robin", 0, 0, 0, 1);

    load_pkt(0, 6);
    run_batch("backpressure", 2, 0, 0, 0);

    load_pkt(1, 3);
    load_pkt(2, 2);
    run_batch("underflow", 0, 5, 5, 0);

    do_reset();
    load_pkt(0, 1);
    load_pkt(3, 1);
    run_batch("single_word", 0, 0, 0, 1);
    load_pkt(3, 1);
    load_pkt(0, 1);
    run_batch("last_is_3", 0, 0, 0, 1);

    push_word(2, {1'b0, 1'b0, 32'h1234_5678});
    load_pkt(2, 2);
    run_batch("orphan", 0, 0, 0, 1);

    for (int b = 0; b < 16; b++) begin
      int total = 0;
      for (int p = 0; p < NP; p++) begin
        int npk = $urandom_range(0, 2);
        for (int k = 0; k < npk; k++) load_pkt(p, $urandom_range(1, 5));
        total += npk;
      end
      if (total == 0) load_pkt($urandom_range(0, NP - 1), $urandom_range(1, 5));
      if (b % 4 == 0) run_batch("rand_full", 0, 0, 0, 1);
      else            run_batch("rand_bp", 1, 0, 3, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eth_rr_arb.md
# eth_rr_arb

Packet-granular round-robin arbiter that shares the switch's single egress datapath among NPORTS ingress receive FIFOs. Each FIFO holds 34-bit entries {end, start, data[31:0]} written by the per-port Ethernet receivers. The arbiter grants one port at a time, pops that port's FIFO word by word until the end-of-packet word, and presents the words on a registered valid/ready output stream. The grant never changes mid-packet.

## Interface
- NPORTS, 4: number of ingress FIFOs (2..16)
- PW, $clog2(NPORTS): port index width (derived)
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- fifo_empty  in  NPORTS  per-port FIFO empty flag
- fifo_rd_data  in  34*NPORTS  per-port head word; slice p = [34p+33:34p] = {end, start, data}; first-word-fall-through, valid when !fifo_empty[p]
- fifo_rd_en  out  NPORTS  per-port pop strobe; at most one bit set per cycle in XFER
- o_data  out  32  egress data
- o_start  out  1  egress start-of-packet
- o_end  out  1  egress end-of-packet
- o_valid  out  1  egress word valid
- o_ready  in  1  egress accept; a transfer occurs when o_valid && o_ready
- o_port  out  PW  index of port sourcing the current o_data word
- o_drop  out  1  orphan-word drop pulse (only with ETH_RR_ARB_ORPHAN_DROP_EN)

## Operation
- States: IDLE, XFER. Registers: state, grant[PW-1:0], last[PW-1:0], output register.
- Reset: state=IDLE, grant=0, last=NPORTS-1, o_valid=0, o_data=0, o_start=0, o_end=0, o_port=0, o_drop=0. fifo_rd_en is 0 in reset and in IDLE.
- IDLE: request vector is req = ~fifo_empty. Scan from last+1, wrapping modulo NPORTS, and take the first set bit. If one is found: grant <= that port and state <= XFER. Otherwise stay in IDLE.
- XFER, pop condition: pop = !fifo_empty[grant] && (!o_valid || o_ready). When pop is true:
  - fifo_rd_en[grant]=1.
  - The output register loads {end, start, data} from the head word, o_port<=grant, o_valid<=1.
  - If the popped word has end=1: state<=IDLE and last<=grant.
- XFER, no pop:
  - If o_valid && o_ready, then o_valid<=0.
  - The output register holds while o_valid && !o_ready; o_data/o_start/o_end/o_port must be stable.
- FIFO empty mid-packet: stay in XFER with the grant locked; wait for more words. No other port is granted.
- Single-word packet (start=1, end=1): one pop, then return to IDLE.
- Words are forwarded unmodified; the arbiter does not check start-bit framing, except as described under Configuration.
- Reset mid-packet: all state is discarded immediately. The partially transferred packet is not completed, and its remainder stays in the FIFO.

## Timing
- fifo_empty[p] falls at cycle 0, with the arbiter in IDLE:
  - grant registers at edge 1.
  - The pop occurs in cycle 1.
  - o_valid=1 with the start word in cycle 2.
- Steady-state throughput is one word per cycle while o_ready=1 and the FIFO is non-empty.
- Between packets there is exactly one IDLE cycle: the end word pops in cycle n, IDLE is in cycle n+1, and the next pop is in cycle n+2. This gives a 1-cycle bubble on o_valid when o_ready is held high.
- fifo_rd_en is combinational from state, grant, fifo_empty, o_valid and o_ready. All o_* outputs are registered.
- Round-robin fairness: with all ports continuously requesting, the grant order is 0,1,2,...,NPORTS-1,0,...

## Configuration
- ETH_RR_ARB_ORPHAN_DROP_EN defined:
  - In IDLE, any port whose head word has start=0 is popped that cycle, with no output. All such ports are popped in parallel, and each one pulses o_drop for the cycle.
  - Such ports are excluded from req that cycle.
  - Only heads with start=1 can win arbitration.
- ETH_RR_ARB_ORPHAN_DROP_EN undefined:
  - Any non-empty port may win arbitration, and its words are forwarded as-is.
  - o_drop is tied to 0.

## Test plan
- Reset, single packet: port 0 holds 3 words (0xA0000001 start, 0xA0000002, 0xA0000003 end) and o_ready=1. Required: o_valid in cycles 2-4, o_start only on the first word, o_end only on the third, o_port=0, then return to IDLE.
- Round robin: all 4 ports hold two 2-word packets and o_ready=1. Required: o_port sequence 0,0,1,1,2,2,3,3,0,0,... with a 1-cycle o_valid gap between packets.
- Backpressure: o_ready=0 for 5 cycles mid-packet. Required: o_data held constant, no fifo_rd_en pulses, and transfer resumes without loss or duplication.
- Mid-packet underflow: port 1 is empty after its start word while port 2 holds a full packet. Required: the grant stays on 1, and port 2's data appears only after port 1's end word.
- Single-word packets: ports 0 and 3 each hold one start+end word. Required: port 0's word, then port 3's word, with last=3 afterward.
- Orphan drop (macro defined): port 2's head word is 0x12345678 with start=0, followed by a valid packet. Required: one o_drop pulse, then only the valid packet is forwarded. Without the macro, the orphan is forwarded with o_start=0.
